parking_rate_engine: RTL



---
 rtl/parking_pkg.sv | 42 ++++
 rtl/parking_rate_engine_if.sv | 35 +++
 rtl/sec_to_min_div.sv | 37 +++
 rtl/parking_rate_engine.sv | 110 +++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types, hour-band boundaries and default rates for the parking rate engine.
package parking_pkg;

    typedef enum logic [1:0] {IDLE, DIV, MUL} state_e;

    typedef enum logic [1:0] {BAND_NIGHT, BAND_AM, BAND_PM, BAND_EVE} band_e;

    localparam logic [4:0] HOUR_AM  = 5'd8;
    localparam logic [4:0] HOUR_PM  = 5'd13;
    localparam logic [4:0] HOUR_EVE = 5'd18;
    localparam logic [4:0] HOUR_END = 5'd24;

    localparam int unsigned DEF_RATE_NIGHT = 1;
    localparam int unsigned DEF_RATE_AM    = 2;
    localparam int unsigned DEF_RATE_PM    = 2;
    localparam int unsigned DEF_RATE_EVE   = 1;

    typedef struct packed {
        band_e band;
        logic  valid;
    } band_info_t;

    function automatic band_info_t hour_to_band(input logic [4:0] hour);
        band_info_t r;
        r.valid = (hour < HOUR_END);
        if (hour < HOUR_AM)       r.band = BAND_NIGHT;
        else if (hour < HOUR_PM)  r.band = BAND_AM;
        else if (hour < HOUR_EVE) r.band = BAND_PM;
        else                      r.band = BAND_EVE;
        return r;
    endfunction

    function automatic int unsigned default_rate(input int unsigned band);
        case (band)
            0:       return DEF_RATE_NIGHT;
            1:       return DEF_RATE_AM;
            2:       return DEF_RATE_PM;
            default: return DEF_RATE_EVE;
        endcase
    endfunction

endpackage

// File: rtl/parking_rate_engine_if.sv
// Request, configuration and result signals between the meter logic and the rate engine.
interface parking_rate_engine_if
    import parking_pkg::*;
#(
    parameter int unsigned LOC_W  = 3,
    parameter int unsigned SEC_W  = 12,
    parameter int unsigned RATE_W = 8,
    parameter int unsigned COST_W = 14
);
    logic              start;
    logic [LOC_W-1:0]  loc;
    logic [4:0]        hour;
    logic [SEC_W-1:0]  sec_count;
    logic              cfg_we;
    logic [LOC_W-1:0]  cfg_loc;
    logic [1:0]        cfg_band;
    logic [RATE_W-1:0] cfg_rate;
    logic              busy;
    logic              done;
    logic [COST_W-1:0] cost;
    logic [SEC_W-1:0]  minutes;
    logic              err_hour;
    logic              sat;

    modport master (
        output start, loc, hour, sec_count, cfg_we, cfg_loc, cfg_band, cfg_rate,
        input  busy, done, cost, minutes, err_hour, sat
    );

    modport slave (
        input  start, loc, hour, sec_count, cfg_we, cfg_loc, cfg_band, cfg_rate,
        output busy, done, cost, minutes, err_hour, sat
    );

endinterface

// File: rtl/sec_to_min_div.sv
// Iterative ceiling divider: one subtraction of SEC_PER_MIN per cycle after load.
module sec_to_min_div
    import parking_pkg::*;
#(
    parameter int unsigned SEC_W       = 12,
    parameter int unsigned SEC_PER_MIN = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEC_W-1:0] sec,
    output logic             fin,
    output logic [SEC_W-1:0] min
);
    localparam logic [SEC_W-1:0] DIVISOR = SEC_W'(SEC_PER_MIN);

    logic [SEC_W-1:0] rem_q;
    logic [SEC_W-1:0] quo_q;

    // Once the remainder drops below the divisor the registers freeze until the next load.
    assign fin = (rem_q < DIVISOR);
    assign min = quo_q + {{(SEC_W-1){1'b0}}, (rem_q != '0)};

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (load) begin
            rem_q <= sec;
            quo_q <= '0;
        end else if (!fin) begin
            rem_q <= rem_q - DIVISOR;
            quo_q <= quo_q + 1'b1;
        end
    end

endmodule

// File: rtl/parking_rate_engine.sv
// Sequential parking cost engine: ceiling seconds-to-minutes, then minutes times a
// programmable per-location, per-band rate with saturation.
module parking_rate_engine
    import parking_pkg::*;
#(
    parameter int unsigned NUM_LOC     = 8,
    parameter int unsigned LOC_W       = $clog2(NUM_LOC),
    parameter int unsigned SEC_W       = 12,
    parameter int unsigned RATE_W      = 8,
    parameter int unsigned COST_W      = 14,
    parameter int unsigned SEC_PER_MIN = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    parking_rate_engine_if.slave  bus
);
    localparam int unsigned PW = SEC_W + RATE_W;
    localparam logic [PW-1:0] COST_MAX = {{(PW-COST_W){1'b0}}, {COST_W{1'b1}}};

    state_e            state_q, state_d;
    logic              div_load;
    logic              div_fin;
    logic [SEC_W-1:0]  min;
    logic [RATE_W-1:0] rate_q;
    logic              req_err_q;
    logic [RATE_W-1:0] rate_tbl [NUM_LOC][4];
    logic              done_q, err_q, sat_q;
    logic [COST_W-1:0] cost_q;
    logic [SEC_W-1:0]  minutes_q;
    band_info_t        bi;
    logic              loc_ok, cfg_loc_ok, over;
    logic [PW-1:0]     product;

    assign bi         = hour_to_band(bus.hour);
    assign loc_ok     = (32'(bus.loc) < NUM_LOC);
    assign cfg_loc_ok = (32'(bus.cfg_loc) < NUM_LOC);
    assign product    = PW'(min) * PW'(rate_q);
    assign over       = (product > COST_MAX);

    sec_to_min_div #(
        .SEC_W       (SEC_W),
        .SEC_PER_MIN (SEC_PER_MIN)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .load (div_load),
        .sec  (bus.sec_count),
        .fin  (div_fin),
        .min  (min)
    );

    always_comb begin
        state_d  = state_q;
        div_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    div_load = 1'b1;
                    state_d  = DIV;
                end
            end
            DIV:     if (div_fin) state_d = MUL;
            MUL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rate_q    <= '0;
            req_err_q <= 1'b0;
            done_q    <= 1'b0;
            cost_q    <= '0;
            minutes_q <= '0;
            err_q     <= 1'b0;
            sat_q     <= 1'b0;
            for (int l = 0; l < NUM_LOC; l++) begin
                for (int b = 0; b < 4; b++) begin
                    rate_tbl[l][b] <= RATE_W'(default_rate(b));
                end
            end
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == MUL);
            // Rate is captured from the pre-write table so a same-edge cfg write is not seen.
            if (state_q == IDLE && bus.start) begin
                rate_q    <= loc_ok ? rate_tbl[bus.loc][bi.band] : '0;
                req_err_q <= !(bi.valid && loc_ok);
            end
            if (state_q == MUL) begin
                minutes_q <= min;
                err_q     <= req_err_q;
                sat_q     <= !req_err_q && over;
                cost_q    <= req_err_q ? '0 : (over ? '1 : product[COST_W-1:0]);
            end
            if (bus.cfg_we && cfg_loc_ok) begin
                rate_tbl[bus.cfg_loc][bus.cfg_band] <= bus.cfg_rate;
            end
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.cost     = cost_q;
    assign bus.minutes  = minutes_q;
    assign bus.err_hour = err_q;
    assign bus.sat      = sat_q;

endmodule
